// File: rtl/bin_to_bcd_display_pkg.sv
// Shared types and constants for the binary-to-BCD display feeder.
// Imported by the converter top and its add-3 correction stage.
package bin_to_bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int BCD_DIGITS  = 4;
  localparam int BCD_W       = 16;
  localparam int SAT_VAL_DEF = 9999;

endpackage

// File: rtl/bcd_add3_step.sv
// Double-dabble correction: every nibble >= 5 gets +3, no inter-nibble carry.
// Applied to the BCD accumulator before each left shift.
module bcd_add3_step
  import bin_to_bcd_display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [BCD_W-1:0] bcd_o
);

  always_comb begin
    bcd_o = bcd_i;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) begin
        bcd_o[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble converter feeding the 4-digit display scanner.
// Saturates at SAT_VAL, one input bit per clock, registered outputs.
module bin_to_bcd_display
  import bin_to_bcd_display_pkg::*;
#(
  parameter int IN_W    = 14,
  parameter int SAT_VAL = SAT_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic [BCD_W-1:0] display_value,
  output logic             done,
  output logic             ovf
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int CMP_W = (IN_W > 14) ? IN_W : 14;
  localparam logic [CMP_W-1:0] SAT_C = CMP_W'(SAT_VAL);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);

  state_e state_q, state_d;
  logic [IN_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0] disp_q, disp_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             sat_hit;

  // Compare in a width that always holds SAT_VAL, so no bits are truncated.
  assign sat_hit = CMP_W'(in_data) > SAT_C;

  bcd_add3_step u_add3 (
    .bcd_i (bcd_q),
    .bcd_o (bcd_adj)
  );

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d      = sat_hit ? SAT_C[IN_W-1:0] : in_data;
          ovf_pend_d = sat_hit;
          bcd_d      = '0;
          cnt_d      = CNT_LOAD;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[IN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_d  = bcd_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign display_value = disp_q;
  assign done          = done_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Bench for bin_to_bcd_display: directed literal checks plus a
// per-cycle comparison against an arithmetic reference model.
module tb_bin_to_bcd_display;

  localparam int IN_W = 14;
  localparam int SAT  = 9999;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic            in_ready;
  logic [15:0]     display_value;
  logic            done;
  logic            ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bin_to_bcd_display #(.IN_W(IN_W), .SAT_VAL(SAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .display_value (display_value),
    .done          (done),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(int v);
    int s;
    s = (v > SAT) ? SAT : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Reference model: one conversion in flight, result due IN_W+1 edges
  // after acceptance, next acceptance possible IN_W+2 edges later.
  logic [15:0] m_disp = '0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;
  logic        m_ready = 1'b1;
  int          m_cyc = 0;
  int          m_free = 0;
  bit          p_vld = 1'b0;
  int          p_at = 0;
  logic [15:0] p_disp = '0;
  logic        p_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_disp  = '0;
      m_ovf   = 1'b0;
      m_done  = 1'b0;
      m_ready = 1'b1;
      m_free  = 0;
      m_cyc   = 0;
      p_vld   = 1'b0;
    end else begin
      m_cyc++;
      m_done = 1'b0;
      if (p_vld && m_cyc == p_at) begin
        m_done = 1'b1;
        m_disp = p_disp;
        m_ovf  = p_ovf;
        p_vld  = 1'b0;
      end
      if (in_valid && m_cyc >= m_free) begin
        p_vld  = 1'b1;
        p_at   = m_cyc + IN_W + 1;
        p_disp = to_bcd(int'(in_data));
        p_ovf  = int'(in_data) > SAT;
        m_free = m_cyc + IN_W + 2;
      end
      m_ready = (m_cyc + 1 >= m_free);
    end
  end

  int last_done = -1;
  bit chk_spacing = 1'b0;

  always @(negedge clk) begin
    n_cmp++;
    if ({display_value, ovf, done, in_ready} !== {m_disp, m_ovf, m_done, m_ready}) begin
      n_bad++;
      $display("FAIL cycle_model cyc=%0d got disp=%h ovf=%b done=%b rdy=%b want disp=%h ovf=%b done=%b rdy=%b",
               cyc, display_value, ovf, done, in_ready, m_disp, m_ovf, m_done, m_ready);
    end
    if (done === 1'b1) begin
      if (chk_spacing && last_done >= 0) begin
        n_cmp++;
        if (cyc - last_done != IN_W + 2) begin
          n_bad++;
          $display("FAIL done_spacing got=%0d want=%0d", cyc - last_done, IN_W + 2);
        end
      end
      last_done = cyc;
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_done(int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout got=none want=done within %0d cycles", budget);
    end
  endtask

  task automatic run_one(int v, logic [15:0] want, logic want_ovf);
    int t0;
    bit ok;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = IN_W'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t0 = cyc;
    check("ready_drop", 32'(in_ready), 32'd0);
    wait_done(40, ok);
    if (ok) begin
      check("latency", cyc - t0, IN_W + 1);
      check("disp", 32'(display_value), 32'(want));
      check("ovf", 32'(ovf), 32'(want_ovf));
      check("ready_back", 32'(in_ready), 32'd1);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t1;
    int got;
    repeat (3) @(posedge clk);
    #1;
    check("rst_disp", 32'(display_value), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    run_one(1234, 16'h1234, 1'b0);
    run_one(0, 16'h0000, 1'b0);
    run_one(9999, 16'h9999, 1'b0);
    run_one(10, 16'h0010, 1'b0);
    run_one(5, 16'h0005, 1'b0);
    run_one(12000, 16'h9999, 1'b1);
    run_one(42, 16'h0042, 1'b0);

    // busy drop: 3333 held during the whole 777 conversion
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = IN_W'(777);
    @(posedge clk);
    #1;
    in_data = IN_W'(3333);
    wait_done(40, ok);
    check("busy_first", 32'(display_value), 32'h0777);
    t1 = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(40, ok);
    check("busy_second", 32'(display_value), 32'h3333);
    check("busy_gap", cyc - t1, IN_W + 2);

    // reset during SHIFT cycle 6
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = IN_W'(4321);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_disp", 32'(display_value), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("midrst_nodone", 32'(done), 32'd0);
    end
    run_one(56, 16'h0056, 1'b0);

    // randomized back-to-back with in_valid held high
    last_done = -1;
    chk_spacing = 1'b1;
    got = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = IN_W'($urandom_range(0, 16383));
    for (int c = 0; c < 1000 * (IN_W + 2) + 50 && got < 1000; c++) begin
      @(negedge clk);
      if (done === 1'b1) got++;
      @(posedge clk);
      #1;
      in_data = IN_W'($urandom_range(0, 16383));
    end
    in_valid = 1'b0;
    check("rand_count", got, 1000);
    chk_spacing = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
